// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: samples VGA hsync/vsync/rgb, recovers pixel coordinates,
// checks line and frame timing and tracks lock.
module vga_rx_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [15:0] px_rgb,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_VIS0 = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_VIS1 = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_TO   = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] V_VIS0 = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_VIS1 = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_TO   = 11'(2 * V_TOTAL - 1);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ALIGN, TRACK, LOCKED} state_t;

  logic        hs_q, hs_d, hs_p_q, hs_p_d;
  logic        vs_q, vs_d, vs_p_q, vs_p_d;
  logic [15:0] rgb_s_q, rgb_s_d, rgb_c_q, rgb_c_d;
  logic        ce1_q, ce1_d, ce2_q, ce2_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0] h_inc, v_inc;
  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        h_arm_q, h_arm_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic        locked_q, locked_d;
  logic        px_valid_q, px_valid_d;
  logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic [15:0] px_rgb_q, px_rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        last_q, last_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        hs_le, vs_le, trk, chk_on;
  logic        h_bad, h_to, v_bad, v_to, tmo;
  logic        h_vis, v_vis;

  // Leading edge of an active-low sync is its high-to-low transition.
  assign hs_le = hs_p_q & ~hs_q;
  assign vs_le = vs_p_q & ~vs_q;
  assign trk   = (state_q == TRACK) || (state_q == LOCKED);

  always_comb begin
    hs_d    = hs_q;
    hs_p_d  = hs_p_q;
    vs_d    = vs_q;
    vs_p_d  = vs_p_q;
    rgb_s_d = rgb_s_q;
    if (pix_ce) begin
      hs_d    = hsync;
      vs_d    = vsync;
      hs_p_d  = hs_q;
      vs_p_d  = vs_q;
      rgb_s_d = rgb;
    end
    ce1_d = pix_ce;
    ce2_d = ce1_q;
  end

  always_comb begin
    h_inc = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 11'd1;
    v_inc = (v_cnt_q == CNT_MAX) ? v_cnt_q : v_cnt_q + 11'd1;
    h_bad = hs_le && h_arm_q && (h_cnt_q != H_LAST);
    h_to  = !hs_le && (h_cnt_q == H_TO);
    v_bad = vs_le && trk && (v_cnt_q != V_LAST);
    v_to  = hs_le && !vs_le && (v_cnt_q == V_TO);
    chk_on  = ce1_q && (state_q != SEARCH);
    h_err_d = chk_on && (h_bad || h_to);
    v_err_d = chk_on && (v_bad || v_to);
    tmo     = chk_on && (h_to || v_to);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    state_d = state_q;
    good_d  = good_q;
    h_arm_d = h_arm_q;
    rgb_c_d = rgb_c_q;
    if (ce1_q) begin
      h_cnt_d = hs_le ? 11'd0 : h_inc;
      if (vs_le) v_cnt_d = 11'd0;
      else if (hs_le) v_cnt_d = v_inc;
      rgb_c_d = rgb_s_q;
      h_arm_d = (state_q != SEARCH) && (h_arm_q || hs_le);
      unique case (state_q)
        SEARCH: if (hs_le) state_d = ALIGN;
        ALIGN: begin
          if (tmo) state_d = SEARCH;
          else if (vs_le) begin
            state_d = TRACK;
            good_d  = 8'd0;
          end
        end
        default: begin
          if (tmo) state_d = SEARCH;
          else if (h_err_d || v_err_d) state_d = ALIGN;
          else if (vs_le && state_q == TRACK) begin
            good_d = good_q + 8'd1;
            if (good_d >= LOCK_N) state_d = LOCKED;
          end
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_comb begin
    h_vis = (h_cnt_q >= H_VIS0) && (h_cnt_q < H_VIS1);
    v_vis = (v_cnt_q >= V_VIS0) && (v_cnt_q < V_VIS1);
    px_valid_d = ce2_q && trk && h_vis && v_vis;
    px_x_d   = px_x_q;
    px_y_d   = px_y_q;
    px_rgb_d = px_rgb_q;
    if (px_valid_d) begin
      px_x_d   = 10'(h_cnt_q - H_VIS0);
      px_y_d   = 10'(v_cnt_q - V_VIS0);
      px_rgb_d = rgb_c_q;
    end
    frame_start_d = px_valid_d && (h_cnt_q == H_VIS0)
                    && (v_cnt_q == V_VIS0);
    last_d = px_valid_d && (h_cnt_q == H_VIS1 - 11'd1)
             && (v_cnt_q == V_VIS1 - 11'd1);
    frame_done_d = last_q;
    frame_cnt_d  = frame_cnt_q + {7'd0, last_q};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hs_q          <= 1'b1;
      hs_p_q        <= 1'b1;
      vs_q          <= 1'b1;
      vs_p_q        <= 1'b1;
      rgb_s_q       <= '0;
      rgb_c_q       <= '0;
      ce1_q         <= 1'b0;
      ce2_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      h_arm_q       <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      locked_q      <= 1'b0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_rgb_q      <= '0;
      frame_start_q <= 1'b0;
      last_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hs_q          <= hs_d;
      hs_p_q        <= hs_p_d;
      vs_q          <= vs_d;
      vs_p_q        <= vs_p_d;
      rgb_s_q       <= rgb_s_d;
      rgb_c_q       <= rgb_c_d;
      ce1_q         <= ce1_d;
      ce2_q         <= ce2_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      state_q       <= state_d;
      good_q        <= good_d;
      h_arm_q       <= h_arm_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      locked_q      <= locked_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_rgb_q      <= px_rgb_d;
      frame_start_q <= frame_start_d;
      last_q        <= last_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_rgb      = px_rgb_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
